// File: rtl/note_display_pkg.sv
// Shared types and constants for the note display decoder.
// Segment patterns are active-high, bit order {a,b,c,d,e,f,g}.
package note_display_pkg;

   typedef logic [6:0] seg7_t;

   // Letter-name glyphs
   localparam seg7_t SEG_C    = 7'b1001110;
   localparam seg7_t SEG_D    = 7'b0111101;
   localparam seg7_t SEG_E    = 7'b1001111;
   localparam seg7_t SEG_F    = 7'b1000111;
   localparam seg7_t SEG_G    = 7'b1011110;
   localparam seg7_t SEG_A    = 7'b1110111;
   localparam seg7_t SEG_B    = 7'b0011111;

   // Scale-degree glyphs
   localparam seg7_t SEG_1    = 7'b0110000;
   localparam seg7_t SEG_2    = 7'b1101101;
   localparam seg7_t SEG_3    = 7'b1111001;
   localparam seg7_t SEG_4    = 7'b0110011;
   localparam seg7_t SEG_5    = 7'b1011011;
   localparam seg7_t SEG_6    = 7'b1011111;
   localparam seg7_t SEG_7    = 7'b1110000;

   localparam seg7_t SEG_DASH = 7'b0000001;
   localparam seg7_t SEG_OFF  = 7'b0000000;

   localparam logic [2:0] NOTE_C    = 3'd0;
   localparam logic [2:0] NOTE_D    = 3'd1;
   localparam logic [2:0] NOTE_E    = 3'd2;
   localparam logic [2:0] NOTE_F    = 3'd3;
   localparam logic [2:0] NOTE_G    = 3'd4;
   localparam logic [2:0] NOTE_A    = 3'd5;
   localparam logic [2:0] NOTE_B    = 3'd6;
   localparam logic [2:0] NOTE_REST = 3'd7;

endpackage

// File: rtl/note_seg_lut.sv
// Combinational map from {tom, nota} to an active-high segment pattern.
// The rest code yields a dash in both notations.
module note_seg_lut
   import note_display_pkg::*;
(
   input  logic       tom,
   input  logic [2:0] nota,
   output seg7_t      seg
);

   always_comb begin
      seg = SEG_DASH;
      if (!tom) begin
         case (nota)
            NOTE_C:    seg = SEG_C;
            NOTE_D:    seg = SEG_D;
            NOTE_E:    seg = SEG_E;
            NOTE_F:    seg = SEG_F;
            NOTE_G:    seg = SEG_G;
            NOTE_A:    seg = SEG_A;
            NOTE_B:    seg = SEG_B;
            NOTE_REST: seg = SEG_DASH;
         endcase
      end else begin
         case (nota)
            NOTE_C:    seg = SEG_1;
            NOTE_D:    seg = SEG_2;
            NOTE_E:    seg = SEG_3;
            NOTE_F:    seg = SEG_4;
            NOTE_G:    seg = SEG_5;
            NOTE_A:    seg = SEG_6;
            NOTE_B:    seg = SEG_7;
            NOTE_REST: seg = SEG_DASH;
         endcase
      end
   end

endmodule

// File: rtl/note_display_decoder.sv
// Registered 7-segment note decoder. Polarity is folded in before the
// flop so the register holds the final pin value.
module note_display_decoder
   import note_display_pkg::*;
#(
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tom,
   input  logic [2:0] nota,
   output logic [6:0] saida
);

   localparam seg7_t POL_MASK = ACTIVE_LOW ? 7'b1111111 : 7'b0000000;

   seg7_t seg;
   seg7_t seg_pin;

   note_seg_lut u_lut (
      .tom  (tom),
      .nota (nota),
      .seg  (seg)
   );

   assign seg_pin = seg ^ POL_MASK;

   always_ff @(posedge clk) begin
      if (rst) saida <= SEG_OFF ^ POL_MASK;
      else     saida <= seg_pin;
   end

endmodule

// File: tb/tb_note_display_decoder.sv
// Directed bench for note_display_decoder; an active-high and an
// active-low instance share the same inputs.
module tb_note_display_decoder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tom = 1'b0;
   logic [2:0] nota = 3'd0;
   logic [6:0] saida_h;
   logic [6:0] saida_l;

   int checks = 0;
   int errors = 0;

   logic [6:0] let_tab [8] = '{7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111,
                               7'b1011110, 7'b1110111, 7'b0011111, 7'b0000001};
   logic [6:0] deg_tab [8] = '{7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                               7'b1011011, 7'b1011111, 7'b1110000, 7'b0000001};

   always #5 clk = ~clk;

   note_display_decoder #(.ACTIVE_LOW(1'b0)) dut_h (
      .clk(clk), .rst(rst), .tom(tom), .nota(nota), .saida(saida_h)
   );

   note_display_decoder #(.ACTIVE_LOW(1'b1)) dut_l (
      .clk(clk), .rst(rst), .tom(tom), .nota(nota), .saida(saida_l)
   );

   // Apply inputs on the falling edge, then step past the next rising edge.
   task automatic drive(input logic r, input logic t, input logic [2:0] n);
      @(negedge clk);
      rst = r; tom = t; nota = n;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [6:0] exp;
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b0, 3'd2);
         checks++;
         if (saida_h !== 7'b0000000) begin
            errors++;
            $display("FAIL reset_hold_%0d: got %b want %b", i, saida_h, 7'b0000000);
         end
      end
      drive(1'b0, 1'b0, 3'd2);
      exp = 7'b1001111;
      checks++;
      if (saida_h !== exp) begin
         errors++;
         $display("FAIL reset_release: got %b want %b", saida_h, exp);
      end
   endtask

   task automatic test_letter_sweep();
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 1'b0, 3'(i));
         checks++;
         if (saida_h !== let_tab[i]) begin
            errors++;
            $display("FAIL letter_%0d: got %b want %b", i, saida_h, let_tab[i]);
         end
         checks++;
         if (saida_l !== ~let_tab[i]) begin
            errors++;
            $display("FAIL letter_al_%0d: got %b want %b", i, saida_l, ~let_tab[i]);
         end
      end
   endtask

   task automatic test_degree_sweep();
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 1'b1, 3'(i));
         checks++;
         if (saida_h !== deg_tab[i]) begin
            errors++;
            $display("FAIL degree_%0d: got %b want %b", i, saida_h, deg_tab[i]);
         end
         checks++;
         if (saida_l !== ~deg_tab[i]) begin
            errors++;
            $display("FAIL degree_al_%0d: got %b want %b", i, saida_l, ~deg_tab[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [6:0] exp;
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, 1'(i % 2), 3'd5);
         exp = (i % 2 == 0) ? 7'b1110111 : 7'b1011111;
         checks++;
         if (saida_h !== exp) begin
            errors++;
            $display("FAIL toggle_%0d: got %b want %b", i, saida_h, exp);
         end
      end
   endtask

   task automatic test_mid_reset();
      logic [6:0] exp;
      for (int i = 0; i < 6; i++) begin
         drive(1'(i == 3), 1'b0, 3'(i));
         exp = (i == 3) ? 7'b0000000 : let_tab[i];
         checks++;
         if (saida_h !== exp) begin
            errors++;
            $display("FAIL midreset_%0d: got %b want %b", i, saida_h, exp);
         end
      end
   endtask

   task automatic test_active_low();
      drive(1'b1, 1'b0, 3'd0);
      checks++;
      if (saida_l !== 7'b1111111) begin
         errors++;
         $display("FAIL al_reset: got %b want %b", saida_l, 7'b1111111);
      end
      drive(1'b0, 1'b0, 3'd0);
      checks++;
      if (saida_l !== 7'b0110001) begin
         errors++;
         $display("FAIL al_c: got %b want %b", saida_l, 7'b0110001);
      end
      drive(1'b0, 1'b0, 3'd7);
      checks++;
      if (saida_l !== 7'b1111110) begin
         errors++;
         $display("FAIL al_rest: got %b want %b", saida_l, 7'b1111110);
      end
      // Holding inputs keeps the output steady.
      drive(1'b0, 1'b0, 3'd7);
      checks++;
      if (saida_h !== 7'b0000001) begin
         errors++;
         $display("FAIL hold_rest: got %b want %b", saida_h, 7'b0000001);
      end
   endtask

   initial begin
      test_reset();
      test_letter_sweep();
      test_degree_sweep();
      test_back_to_back();
      test_mid_reset();
      test_active_low();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
